// File: rtl/spi_tx_fifo.sv
// Byte FIFO feeding spi_ctrl: queues CPU writes and issues them one at a time as
// single-cycle start pulses carrying {dc, end_txn, byte}, pacing on spi_busy.
module spi_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [9:0]    wr_data,
    input  logic          flush,
    input  logic          clr_overflow,
    input  logic          spi_busy,
    output logic          spi_start,
    output logic [7:0]    spi_data,
    output logic          spi_dc,
    output logic          spi_end_txn,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          idle
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StArm   = 2'd2;
    localparam logic [1:0] StWait  = 2'd3;

    localparam logic [AW:0]   LvlFull = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LvlOne  = (AW+1)'(1);
    localparam logic [AW-1:0] PtrOne  = AW'(1);

    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [1:0]    r_state;
    logic [1:0]    w_state_d;
    logic          r_overflow;
    logic          r_spi_start;
    logic [7:0]    r_spi_data;
    logic          r_spi_dc;
    logic          r_spi_end_txn;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_accept;
    logic w_drop;

    assign w_full  = (r_level == LvlFull);
    assign w_empty = (r_level == '0);

    // Pop decision uses the registered level only; a write landing this cycle waits.
    assign w_pop    = ((r_state == StIdle) || (r_state == StWait)) &&
                      !w_empty && !spi_busy && !flush;
    assign w_accept = wr_en && !flush && (!w_full || w_pop);
    assign w_drop   = wr_en && !flush && w_full && !w_pop;

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (w_pop) w_state_d = StStart;
            StStart: w_state_d = StArm;
            StArm:   w_state_d = StWait;
            StWait: begin
                if (!spi_busy) w_state_d = w_pop ? StStart : StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_state       <= StIdle;
            r_overflow    <= 1'b0;
            r_spi_start   <= 1'b0;
            r_spi_data    <= '0;
            r_spi_dc      <= 1'b0;
            r_spi_end_txn <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_spi_start <= w_pop;

            if (w_accept) r_wr_ptr <= r_wr_ptr + PtrOne;

            // Flush never coincides with a pop, so the read pointer has one source per cycle.
            if (flush) begin
                r_rd_ptr <= r_wr_ptr;
                r_level  <= '0;
            end else begin
                if (w_pop) r_rd_ptr <= r_rd_ptr + PtrOne;
                if (w_accept && !w_pop) r_level <= r_level + LvlOne;
                else if (!w_accept && w_pop) r_level <= r_level - LvlOne;
            end

            if (w_drop) r_overflow <= 1'b1;
            else if (clr_overflow) r_overflow <= 1'b0;

            if (w_pop) begin
                r_spi_dc      <= r_mem[r_rd_ptr][9];
                r_spi_end_txn <= r_mem[r_rd_ptr][8];
                r_spi_data    <= r_mem[r_rd_ptr][7:0];
            end
        end
    end

    assign spi_start   = r_spi_start;
    assign spi_data    = r_spi_data;
    assign spi_dc      = r_spi_dc;
    assign spi_end_txn = r_spi_end_txn;
    assign full        = w_full;
    assign empty       = w_empty;
    assign level       = r_level;
    assign overflow    = r_overflow;
    assign idle        = w_empty && (r_state == StIdle) && !spi_busy;

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Self-checking bench for spi_tx_fifo: directed scenarios plus random traffic, all
// compared cycle by cycle against a queue-based reference model.
module tb_spi_tx_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          rstn;
    logic          wr_en;
    logic [9:0]    wr_data;
    logic          flush;
    logic          clr_overflow;
    logic          spi_busy;
    logic          spi_start;
    logic [7:0]    spi_data;
    logic          spi_dc;
    logic          spi_end_txn;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          idle;

    spi_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .flush        (flush),
        .clr_overflow (clr_overflow),
        .spi_busy     (spi_busy),
        .spi_start    (spi_start),
        .spi_data     (spi_data),
        .spi_dc       (spi_dc),
        .spi_end_txn  (spi_end_txn),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .idle         (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queued entries, sticky overflow, last issued entry, and the
    // number of cycles after an issue during which busy is not yet consulted.
    logic [9:0] m_q[$];
    logic       m_ovf;
    logic       m_start;
    logic [7:0] m_data;
    logic       m_dc;
    logic       m_end;
    int         m_cool;
    logic       m_settled;

    // Simple spi_ctrl stand-in driving busy after each start.
    logic       force_busy;
    int         busy_cnt;
    int         busy_len;
    logic       rand_busy;

    int         n_starts;
    logic [9:0] issued[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf     = 1'b0;
        m_start   = 1'b0;
        m_data    = 8'h00;
        m_dc      = 1'b0;
        m_end     = 1'b0;
        m_cool    = 0;
        m_settled = 1'b1;
    endtask

    task automatic model_edge();
        int   sz;
        logic pop;
        logic acc;
        logic [9:0] head;
        sz  = m_q.size();
        pop = (m_cool == 0) && !spi_busy && (sz > 0) && !flush;
        acc = wr_en && !flush && ((sz < DEPTH) || pop);
        if (wr_en && !flush && (sz == DEPTH) && !pop) m_ovf = 1'b1;
        else if (clr_overflow) m_ovf = 1'b0;
        m_start = pop;
        if (pop) begin
            head   = m_q.pop_front();
            m_dc   = head[9];
            m_end  = head[8];
            m_data = head[7:0];
        end
        if (flush) m_q.delete();
        if (acc) m_q.push_back(wr_data);
        if (pop) m_settled = 1'b0;
        else if (m_cool == 0 && !spi_busy) m_settled = 1'b1;
        if (pop) m_cool = 2;
        else if (m_cool > 0) m_cool--;
    endtask

    task automatic check_outputs();
        check_eq("spi_start", spi_start, m_start);
        check_eq("spi_data", spi_data, m_data);
        check_eq("spi_dc", spi_dc, m_dc);
        check_eq("spi_end_txn", spi_end_txn, m_end);
        check_eq("level", level, m_q.size());
        check_eq("full", full, m_q.size() == DEPTH);
        check_eq("empty", empty, m_q.size() == 0);
        check_eq("overflow", overflow, m_ovf);
        check_eq("idle", idle, (m_q.size() == 0) && m_settled && !spi_busy);
        if (spi_start === 1'b1) begin
            n_starts++;
            issued.push_back({spi_dc, spi_end_txn, spi_data});
        end
    endtask

    // Entered and left at a negedge.
    task automatic step(input logic we, input logic [9:0] wd, input logic fl, input logic clr);
        wr_en        = we;
        wr_data      = wd;
        flush        = fl;
        clr_overflow = clr;
        spi_busy     = force_busy || (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        if (m_start) busy_cnt = rand_busy ? int'($urandom_range(0, 6)) : busy_len;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 10'h000, 1'b0, 1'b0);
    endtask

    initial begin
        int s0;
        rstn         = 1'b0;
        wr_en        = 1'b0;
        wr_data      = '0;
        flush        = 1'b0;
        clr_overflow = 1'b0;
        spi_busy     = 1'b0;
        force_busy   = 1'b0;
        busy_cnt     = 0;
        busy_len     = 3;
        rand_busy    = 1'b0;
        n_starts     = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rstn = 1'b1;

        // Single write with busy low: issued on the following edge.
        step(1'b1, 10'h0A5, 1'b0, 1'b0);
        check_eq("t1_level_before_pop", level, 1);
        step(1'b0, 10'h000, 1'b0, 1'b0);
        check_eq("t1_start", spi_start, 1);
        check_eq("t1_data", spi_data, 8'hA5);
        check_eq("t1_dc", spi_dc, 0);
        check_eq("t1_empty", empty, 1);
        run_idle(10);

        // Fill while busy, fifth write overflows, then drain in order.
        issued.delete();
        force_busy = 1'b1;
        for (int i = 1; i <= 5; i++) step(1'b1, 10'(i), 1'b0, 1'b0);
        check_eq("t2_full", full, 1);
        check_eq("t2_level", level, 4);
        check_eq("t2_overflow", overflow, 1);
        run_idle(20);
        force_busy = 1'b0;
        run_idle(60);
        check_eq("t2_issued", issued.size(), 4);
        for (int i = 0; i < issued.size() && i < 4; i++) check_eq("t2_order", issued[i], i + 1);
        step(1'b0, 10'h000, 1'b0, 1'b1);
        check_eq("t2_ovf_clr", overflow, 0);

        // Full FIFO, busy falls in WAIT while a write arrives on the pop cycle.
        busy_len = 0;
        step(1'b1, 10'h010, 1'b0, 1'b0);
        step(1'b1, 10'h011, 1'b0, 1'b0);
        force_busy = 1'b1;
        for (int i = 2; i <= 4; i++) step(1'b1, 10'(16 + i), 1'b0, 1'b0);
        check_eq("t3_full", full, 1);
        force_busy = 1'b0;
        step(1'b1, 10'h015, 1'b0, 1'b0);
        check_eq("t3_level", level, 4);
        check_eq("t3_overflow", overflow, 0);
        check_eq("t3_start", spi_start, 1);
        check_eq("t3_data", spi_data, 8'h11);
        run_idle(40);

        // Flush behind an in-flight byte.
        busy_len = 8;
        step(1'b1, 10'h020, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) step(1'b1, 10'(32 + i), 1'b0, 1'b0);
        check_eq("t4_level_queued", level, 3);
        step(1'b0, 10'h000, 1'b1, 1'b0);
        check_eq("t4_level_flushed", level, 0);
        s0 = n_starts;
        run_idle(20);
        check_eq("t4_no_start", n_starts - s0, 0);
        check_eq("t4_idle", idle, 1);

        // dc and end_txn forwarded with the byte.
        step(1'b1, 10'h3FF, 1'b0, 1'b0);
        step(1'b0, 10'h000, 1'b0, 1'b0);
        check_eq("t5_start", spi_start, 1);
        check_eq("t5_data", spi_data, 8'hFF);
        check_eq("t5_dc", spi_dc, 1);
        check_eq("t5_end", spi_end_txn, 1);
        run_idle(20);

        // Asynchronous reset in WAIT with two entries queued.
        busy_len = 10;
        step(1'b1, 10'h030, 1'b0, 1'b0);
        step(1'b1, 10'h031, 1'b0, 1'b0);
        step(1'b1, 10'h032, 1'b0, 1'b0);
        step(1'b0, 10'h000, 1'b0, 1'b0);
        check_eq("t6_level_pre", level, 2);
        check_eq("t6_busy_pre", spi_busy, 1);
        rstn     = 1'b0;
        busy_cnt = 0;
        spi_busy = 1'b0;
        #1;
        model_reset();
        check_eq("t6_start", spi_start, 0);
        check_eq("t6_data", spi_data, 0);
        check_eq("t6_level", level, 0);
        check_eq("t6_empty", empty, 1);
        check_eq("t6_full", full, 0);
        check_eq("t6_idle", idle, 1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        s0   = n_starts;
        run_idle(20);
        check_eq("t6_no_start", n_starts - s0, 0);

        // Random traffic.
        rand_busy = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) force_busy = ~force_busy;
            step(1'b0 | ($urandom_range(0, 99) < 45), 10'($urandom_range(0, 1023)),
                 1'b0 | ($urandom_range(0, 99) < 2), 1'b0 | ($urandom_range(0, 99) < 5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
